// File: rtl/apb_master_bridge.sv
// Bridge from the core's request/response bus to APB3: decodes one-hot psel,
// sequences SETUP/ACCESS and returns a one-cycle response, with an ACCESS timeout.
module apb_master_bridge #(
    parameter int unsigned AW      = 8,
    parameter int unsigned SLV_N   = 4,
    parameter int unsigned SLV_AW  = 5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AW-1:0]       req_addr,
    input  logic                req_we,
    input  logic [31:0]         req_wd,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rd,
    output logic                rsp_err,
    output logic [AW-1:0]       paddr,
    output logic [31:0]         pwdata,
    output logic                pwrite,
    output logic [SLV_N-1:0]    psel,
    output logic                penable,
    input  logic [SLV_N*32-1:0] prdata,
    input  logic [SLV_N-1:0]    pready,
    input  logic [SLV_N-1:0]    pslverr
);
    localparam int unsigned IDX_W = AW - SLV_AW;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      paddr_q, paddr_d;
    logic [31:0]        pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic [SLV_N-1:0]   psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rd_q, rsp_rd_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   req_idx;
    logic               dec_hit;
    logic               sel_ready;
    logic               sel_err;
    logic [31:0]        sel_rdata;

    assign req_idx = req_addr[AW-1:SLV_AW];
    assign dec_hit = (32'(req_idx) < SLV_N);

    // The active psel bit steers the response mux; unselected slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = 32'h0;
        for (int unsigned i = 0; i < SLV_N; i++) begin
            if (psel_q[i]) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rsp_rd_d  = rsp_rd_q;
        rsp_err_d = rsp_err_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwdata_d = req_wd;
                    pwrite_d = req_we;
                    if (dec_hit) begin
                        for (int unsigned i = 0; i < SLV_N; i++) begin
                            psel_d[i] = (32'(req_idx) == i);
                        end
                        penable_d = 1'b0;
                        state_d   = ST_SETUP;
                    end else begin
                        rsp_rd_d  = 32'h0;
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Ready on the timeout-limit cycle still completes normally.
                if (sel_ready) begin
                    rsp_rd_d  = pwrite_q ? 32'h0 : sel_rdata;
                    rsp_err_d = sel_err;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    rsp_rd_d  = 32'h0;
                    rsp_err_d = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= 32'h0;
            pwrite_q    <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= 32'h0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;

endmodule
